// File: rtl/inv_chk_pkg.sv
// Shared types and default constants for the inverter response checker.
package inv_chk_pkg;

  localparam int unsigned DEF_CNT_W      = 8;
  localparam int unsigned DEF_SETTLE_CYC = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    SETTLE    = 2'd2,
    CHECK     = 2'd3
  } chk_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear takes priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] out
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out = cnt_q;

endmodule

// File: rtl/inv_response_checker.sv
// Waits a settle time after each stimulus change, then checks the inverter
// output against the complement of its input and keeps saturating tallies.
module inv_response_checker
  import inv_chk_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             en_in,
  input  logic             clear_in,
  input  logic             a_in,
  input  logic             y_in,
  output logic             chk_valid_out,
  output logic             chk_pass_out,
  output logic [CNT_W-1:0] sample_cnt_out,
  output logic [CNT_W-1:0] err_cnt_out,
  output logic             err_flag_out
);

  localparam int unsigned        SC_W        = $clog2(SETTLE_CYC + 1);
  localparam logic [SC_W-1:0]    SETTLE_LOAD = SC_W'(SETTLE_CYC);

  chk_state_e       state_d, state_q;
  logic [SC_W-1:0]  settle_cnt_d, settle_cnt_q;
  logic             a_d, a_q;
  logic             chk_valid_d, chk_valid_q;
  logic             chk_pass_d, chk_pass_q;
  logic             err_flag_d, err_flag_q;
  logic             chg;
  logic             check_done;
  logic             check_fail;

  always_comb begin
    a_d          = a_in;
    chg          = (a_in != a_q);
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    check_done   = 1'b0;

    // A sampled change from any enabled state (re)starts the settle window,
    // which also discards a check that would otherwise complete in CHECK.
    if (!en_in) begin
      state_d = IDLE;
    end else if (chg) begin
      state_d      = SETTLE;
      settle_cnt_d = SETTLE_LOAD;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d      = SETTLE;
          settle_cnt_d = SETTLE_LOAD;
        end
        WAIT_EDGE: begin
          state_d = WAIT_EDGE;
        end
        SETTLE: begin
          settle_cnt_d = settle_cnt_q - SC_W'(1);
          if (settle_cnt_q == SC_W'(1)) begin
            state_d = CHECK;
          end
        end
        CHECK: begin
          check_done = 1'b1;
          state_d    = WAIT_EDGE;
        end
      endcase
    end

    check_fail  = check_done && (y_in == a_in);
    chk_valid_d = check_done;
    chk_pass_d  = check_done ? (y_in == ~a_in) : chk_pass_q;
    err_flag_d  = clear_in ? 1'b0 : (err_flag_q | check_fail);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      a_q          <= 1'b0;
      chk_valid_q  <= 1'b0;
      chk_pass_q   <= 1'b0;
      err_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      a_q          <= a_d;
      chk_valid_q  <= chk_valid_d;
      chk_pass_q   <= chk_pass_d;
      err_flag_q   <= err_flag_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .inc   (check_done),
    .clr   (clear_in),
    .out   (sample_cnt_out)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .inc   (check_fail),
    .clr   (clear_in),
    .out   (err_cnt_out)
  );

  assign chk_valid_out = chk_valid_q;
  assign chk_pass_out  = chk_pass_q;
  assign err_flag_out  = err_flag_q;

endmodule

// File: tb/tb_inv_response_checker.sv
// Bench for inv_response_checker: directed scenarios plus random stimulus,
// checked every cycle against a window-based model of when checks complete.
module tb_inv_response_checker;

  localparam int S = 2;

  logic       clk_in = 1'b0;
  logic       rst_n_in, en_in, clear_in, a_in, y_in, y_man;
  int         mode;
  logic       chk_valid_out, chk_pass_out, err_flag_out;
  logic [7:0] sample_cnt_out, err_cnt_out;
  logic       v2, p2, f2;
  logic [1:0] s2, e2;

  int n_vec = 0;
  int n_err = 0;

  assign y_in = (mode == 1) ? ~a_in : (mode == 2) ? a_in : y_man;

  always #5 clk_in = ~clk_in;

  inv_response_checker #(.CNT_W(8), .SETTLE_CYC(S)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .en_in(en_in), .clear_in(clear_in),
    .a_in(a_in), .y_in(y_in), .chk_valid_out(chk_valid_out),
    .chk_pass_out(chk_pass_out), .sample_cnt_out(sample_cnt_out),
    .err_cnt_out(err_cnt_out), .err_flag_out(err_flag_out)
  );

  inv_response_checker #(.CNT_W(2), .SETTLE_CYC(S)) dut2 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .en_in(en_in), .clear_in(clear_in),
    .a_in(a_in), .y_in(y_in), .chk_valid_out(v2),
    .chk_pass_out(p2), .sample_cnt_out(s2),
    .err_cnt_out(e2), .err_flag_out(f2)
  );

  function automatic void chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic int sat_upd(input int cur, input bit inc, input bit clr, input int max);
    if (clr) return 0;
    if (inc && cur < max) return cur + 1;
    return cur;
  endfunction

  // Model: a check completes at edge t when a start event (enabled change,
  // or enable after idle) happened at edge t-S-1 and every edge t-S..t was
  // enabled with no sampled change.
  int n, last_trig, last_nq;
  bit a_prev, prev_en, valid_m, pass_m, flag_m;
  int smp_m, err_m, smp2_m, err2_m;

  always @(posedge clk_in) begin
    bit chg, quiet, trig, did, fail;
    if (!rst_n_in) begin
      n = 0; last_trig = -100; last_nq = 0;
      a_prev = 0; prev_en = 0;
      valid_m = 0; pass_m = 0; flag_m = 0;
      smp_m = 0; err_m = 0; smp2_m = 0; err2_m = 0;
    end else begin
      n++;
      chg   = (a_in != a_prev);
      quiet = en_in && !chg;
      trig  = en_in && (chg || !prev_en);
      if (!quiet) last_nq = n;
      if (trig) last_trig = n;
      did  = quiet && (last_trig == n - S - 1) && (last_nq < n - S);
      fail = did && (y_in == a_in);
      valid_m = did;
      if (did) pass_m = (y_in != a_in);
      smp_m  = sat_upd(smp_m,  did,  clear_in, 255);
      err_m  = sat_upd(err_m,  fail, clear_in, 255);
      smp2_m = sat_upd(smp2_m, did,  clear_in, 3);
      err2_m = sat_upd(err2_m, fail, clear_in, 3);
      flag_m = clear_in ? 1'b0 : (flag_m | fail);
      a_prev  = a_in;
      prev_en = en_in;
    end
    #1;
    chk("valid", chk_valid_out, valid_m);
    chk("pass", chk_pass_out, pass_m);
    chk("sample_cnt", sample_cnt_out, smp_m);
    chk("err_cnt", err_cnt_out, err_m);
    chk("err_flag", err_flag_out, flag_m);
    chk("valid_w2", v2, valid_m);
    chk("pass_w2", p2, pass_m);
    chk("sample_cnt_w2", s2, smp2_m);
    chk("err_cnt_w2", e2, err2_m);
    chk("err_flag_w2", f2, flag_m);
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    cyc(2);
    rst_n_in = 1'b1;
  endtask

  initial begin
    rst_n_in = 1'b0; en_in = 1'b0; clear_in = 1'b0; a_in = 1'b0; y_man = 1'b1; mode = 0;
    cyc(2);
    chk("rst_sample", sample_cnt_out, 0);
    chk("rst_flag", err_flag_out, 0);
    rst_n_in = 1'b1;

    // Initial check of the current level
    en_in = 1'b1;
    cyc(3);
    chk("t1_early", chk_valid_out, 0);
    cyc(1);
    chk("t1_valid", chk_valid_out, 1);
    chk("t1_pass", chk_pass_out, 1);
    chk("t1_sample", sample_cnt_out, 1);
    chk("t1_err", err_cnt_out, 0);
    cyc(1);
    chk("t1_pulse_end", chk_valid_out, 0);

    // Good inverter, 10 toggles
    mode = 1;
    for (int i = 0; i < 10; i++) begin
      a_in = ~a_in;
      cyc(8);
    end
    chk("t2_sample", sample_cnt_out, 11);
    chk("t2_err", err_cnt_out, 0);
    chk("t2_flag", err_flag_out, 0);

    // One-cycle glitch restarts settle
    a_in = ~a_in; cyc(1);
    a_in = ~a_in; cyc(3);
    chk("t4_no_early", chk_valid_out, 0);
    cyc(1);
    chk("t4_valid", chk_valid_out, 1);
    chk("t4_sample", sample_cnt_out, 12);
    cyc(4);
    chk("t4_once", sample_cnt_out, 12);

    // Enable dropped while in CHECK
    a_in = ~a_in; cyc(3);
    en_in = 1'b0; cyc(1);
    chk("t4_drop_valid", chk_valid_out, 0);
    chk("t4_drop_sample", sample_cnt_out, 12);
    cyc(1);
    en_in = 1'b1; cyc(6);
    chk("t4_reen_sample", sample_cnt_out, 13);

    // Stuck-at fault
    mode = 2; a_in = 1'b0;
    do_reset();
    cyc(6);
    for (int i = 0; i < 4; i++) begin
      a_in = ~a_in;
      cyc(8);
    end
    chk("t3_err", err_cnt_out, 5);
    chk("t3_flag", err_flag_out, 1);
    chk("t3_pass", chk_pass_out, 0);
    clear_in = 1'b1; cyc(1); clear_in = 1'b0;
    chk("t3_clr_err", err_cnt_out, 0);
    chk("t3_clr_flag", err_flag_out, 0);
    cyc(10);
    chk("t3_flag_stays", err_flag_out, 0);

    // Narrow counters saturate; clear on a check edge wins
    a_in = 1'b0;
    do_reset();
    cyc(6);
    for (int i = 0; i < 6; i++) begin
      a_in = ~a_in;
      cyc(8);
    end
    chk("t5_s2_sat", s2, 3);
    chk("t5_e2_sat", e2, 3);
    chk("t5_sample8", sample_cnt_out, 7);
    a_in = ~a_in; cyc(3);
    clear_in = 1'b1; cyc(1); clear_in = 1'b0;
    chk("t5_clr_valid", chk_valid_out, 1);
    chk("t5_clr_s2", s2, 0);
    chk("t5_clr_e2", e2, 0);
    chk("t5_clr_sample8", sample_cnt_out, 0);

    // Async reset mid-SETTLE
    a_in = ~a_in; cyc(8);
    mode = 1;
    a_in = ~a_in; cyc(8);
    chk("t6_pre_sample", sample_cnt_out, 2);
    a_in = ~a_in; cyc(2);
    #2 rst_n_in = 1'b0;
    #1;
    chk("t6_async_valid", chk_valid_out, 0);
    chk("t6_async_pass", chk_pass_out, 0);
    chk("t6_async_sample", sample_cnt_out, 0);
    chk("t6_async_err", err_cnt_out, 0);
    chk("t6_async_flag", err_flag_out, 0);
    cyc(2);
    rst_n_in = 1'b1;
    cyc(3);
    chk("t6_no_early", chk_valid_out, 0);
    cyc(1);
    chk("t6_valid", chk_valid_out, 1);
    chk("t6_sample", sample_cnt_out, 1);

    // Random stimulus
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) a_in = ~a_in;
      en_in    = ($urandom_range(0, 39) != 0);
      clear_in = ($urandom_range(0, 49) == 0);
      if (i % 40 == 0) mode = int'($urandom_range(0, 2));
      y_man = 1'($urandom_range(0, 1));
      cyc(1);
    end
    clear_in = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
